// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU-first arbiter for a shared single-port memory with loader starvation guard and bus lock.
module mem_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          ldr_req,
    input  logic          ldr_lock,
    input  logic          ldr_wr,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);
    typedef enum logic [1:0] {CPU_PRI, LDR_PRI, LDR_LOCK} state_t;
    localparam logic [3:0] MW = 4'(MAX_WAIT);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic cpu_tag, ldr_tag;
    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        case (state)
            CPU_PRI: begin
                cpu_gnt = cpu_req;
                ldr_gnt = !cpu_req && ldr_req;
            end
            LDR_PRI: begin
                ldr_gnt = ldr_req;
                cpu_gnt = !ldr_req && cpu_req;
            end
            default: ldr_gnt = ldr_req;
        endcase
        if (rst) begin
            cpu_gnt = 1'b0;
            ldr_gnt = 1'b0;
        end
        // counter only climbs while the loader is actively losing to the CPU
        cnt_n = (ldr_gnt || !ldr_req) ? 4'd0 : cpu_gnt ? cnt + 4'd1 : cnt;
        case (state)
            CPU_PRI:  state_n = (ldr_gnt && ldr_lock) ? LDR_LOCK : (cnt_n == MW) ? LDR_PRI : CPU_PRI;
            LDR_PRI:  state_n = (ldr_req && ldr_lock) ? LDR_LOCK : CPU_PRI;
            default:  state_n = ldr_lock ? LDR_LOCK : CPU_PRI;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CPU_PRI;
            cnt        <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_tag    <= 1'b0;
            ldr_tag    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            owner      <= 2'b00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            mem_rd     <= (cpu_gnt && !cpu_wr) || (ldr_gnt && !ldr_wr);
            mem_wr     <= (cpu_gnt && cpu_wr) || (ldr_gnt && ldr_wr);
            cpu_tag    <= cpu_gnt && !cpu_wr;
            ldr_tag    <= ldr_gnt && !ldr_wr;
            cpu_rvalid <= cpu_tag;
            ldr_rvalid <= ldr_tag;
            if (cpu_gnt) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                owner     <= 2'b01;
            end else if (ldr_gnt) begin
                mem_addr  <= ldr_addr;
                mem_wdata <= ldr_wdata;
                owner     <= 2'b10;
            end
        end
    end
    assign rdata = (cpu_rvalid || ldr_rvalid) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus a read-return scoreboard fed from observed grants.
module tb_mem_arbiter;
    logic       clk = 1'b0, rst = 1'b1;
    logic       cpu_req = 0, cpu_wr = 0, ldr_req = 0, ldr_lock = 0, ldr_wr = 0;
    logic [4:0] cpu_addr = 0, ldr_addr = 0;
    logic [7:0] cpu_wdata = 0, ldr_wdata = 0;
    logic       cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_rd, mem_wr;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;
    logic [1:0] owner;
    logic [7:0] mem [32];
    logic [7:0] shadow [32];
    typedef struct {logic ldr; logic [7:0] data;} sb_t;
    sb_t sbq[$];
    sb_t e;
    int tests = 0, fails = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_lock(ldr_lock), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
        .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // scoreboard: expectation pushed at grant, popped at rvalid
    always @(negedge clk) begin
        if (rst) sbq.delete();
        else begin
            if (cpu_rvalid || ldr_rvalid) begin
                tests++;
                if (cpu_rvalid && ldr_rvalid) begin
                    fails++; $display("FAIL sb_both_rvalid: cpu_rvalid=1 ldr_rvalid=1, required at most one");
                end else if (sbq.size() == 0) begin
                    fails++; $display("FAIL sb_unexpected: rvalid cpu=%b ldr=%b with no read pending", cpu_rvalid, ldr_rvalid);
                end else begin
                    e = sbq.pop_front();
                    if ({ldr_rvalid, rdata} !== {e.ldr, e.data}) begin
                        fails++; $display("FAIL sb_read: got ldr=%b data=%h, required ldr=%b data=%h", ldr_rvalid, rdata, e.ldr, e.data);
                    end
                end
            end
            if (cpu_gnt) begin
                if (cpu_wr) shadow[cpu_addr] = cpu_wdata;
                else sbq.push_back('{1'b0, shadow[cpu_addr]});
            end
            if (ldr_gnt) begin
                if (ldr_wr) shadow[ldr_addr] = ldr_wdata;
                else sbq.push_back('{1'b1, shadow[ldr_addr]});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        cpu_req = 0; ldr_req = 0; ldr_lock = 0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        cpu_req = 1; ldr_req = 1;
        repeat (2) @(negedge clk);
        tests++;
        if ({cpu_gnt, ldr_gnt} !== 2'b00) begin
            fails++; $display("FAIL reset_gnt: gnt=%b, required 00", {cpu_gnt, ldr_gnt});
        end
        tests++;
        if ({mem_rd, mem_wr, cpu_rvalid, ldr_rvalid, owner, mem_addr, mem_wdata, rdata} !== '0) begin
            fails++; $display("FAIL reset_outs: rd=%b wr=%b rv=%b%b owner=%b addr=%h wd=%h rdata=%h, required all 0",
                mem_rd, mem_wr, cpu_rvalid, ldr_rvalid, owner, mem_addr, mem_wdata, rdata);
        end
        @(posedge clk); #1; rst = 0; cpu_req = 0; ldr_req = 0;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h1A;
        @(negedge clk); tests++;
        if (cpu_gnt !== 1'b1) begin fails++; $display("FAIL cpu_read_gnt: got %b, required 1", cpu_gnt); end
        tick(); cpu_req = 0;
        @(negedge clk); tests++;
        if ({mem_rd, mem_wr, mem_addr, owner} !== {2'b10, 5'h1A, 2'b01}) begin
            fails++; $display("FAIL cpu_read_cmd: rd=%b wr=%b addr=%h owner=%b, required 1 0 1a 01", mem_rd, mem_wr, mem_addr, owner);
        end
        tick();
        @(negedge clk); tests++;
        if ({cpu_rvalid, ldr_rvalid, rdata} !== {2'b10, 8'hB7}) begin
            fails++; $display("FAIL cpu_read_data: rv=%b%b rdata=%h, required 10 b7", cpu_rvalid, ldr_rvalid, rdata);
        end
        tick(); tests++;
        @(negedge clk);
        if ({cpu_rvalid, mem_rd, mem_addr} !== {2'b00, 5'h1A}) begin
            fails++; $display("FAIL idle_hold: rv=%b rd=%b addr=%h, required 0 0 1a", cpu_rvalid, mem_rd, mem_addr);
        end
        idle(1);
    endtask

    task automatic test_starvation();
        ldr_req = 1; ldr_wr = 0; ldr_addr = 5'd2; ldr_lock = 0; cpu_req = 1; cpu_wr = 0;
        for (int i = 0; i < 10; i++) begin
            cpu_addr = 5'(i + 8);
            @(negedge clk); tests++;
            if ({cpu_gnt, ldr_gnt} !== ((i == 4 || i == 9) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL starve_cyc%0d: cpu/ldr gnt=%b, required %b", i, {cpu_gnt, ldr_gnt}, (i == 4 || i == 9) ? 2'b01 : 2'b10);
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_lock();
        for (int i = 0; i < 8; i++) begin
            ldr_req = 1; ldr_lock = 1; ldr_wr = 1; ldr_addr = 5'(i); ldr_wdata = 8'hA0 + 8'(i);
            cpu_req = (i > 0); cpu_wr = 0; cpu_addr = 5'h10;
            @(negedge clk); tests++;
            if ({cpu_gnt, ldr_gnt} !== 2'b01) begin
                fails++; $display("FAIL lock_burst%0d: cpu/ldr gnt=%b, required 01", i, {cpu_gnt, ldr_gnt});
            end
            tick();
        end
        ldr_req = 0; ldr_lock = 0;
        @(negedge clk); tests++;
        if ({cpu_gnt, owner} !== 3'b010) begin
            fails++; $display("FAIL lock_release: cpu_gnt=%b owner=%b, required 0 10", cpu_gnt, owner);
        end
        tick();
        @(negedge clk); tests++;
        if (cpu_gnt !== 1'b1) begin fails++; $display("FAIL lock_cpu_back: cpu_gnt=%b, required 1", cpu_gnt); end
        tick(); cpu_req = 0;
        @(negedge clk); tests++;
        if (owner !== 2'b01) begin fails++; $display("FAIL lock_owner: owner=%b, required 01", owner); end
        idle(3);
    endtask

    task automatic test_pipelined();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'd3;
        @(negedge clk); tests++;
        if (cpu_gnt !== 1'b1) begin fails++; $display("FAIL pipe_cpu_gnt: got %b, required 1", cpu_gnt); end
        tick(); cpu_req = 0; ldr_req = 1; ldr_wr = 0; ldr_addr = 5'd4;
        @(negedge clk); tests++;
        if (ldr_gnt !== 1'b1) begin fails++; $display("FAIL pipe_ldr_gnt: got %b, required 1", ldr_gnt); end
        tick(); ldr_req = 0;
        @(negedge clk); tests++;
        if ({cpu_rvalid, ldr_rvalid, rdata} !== {2'b10, 8'hA3}) begin
            fails++; $display("FAIL pipe_cpu_data: rv=%b%b rdata=%h, required 10 a3", cpu_rvalid, ldr_rvalid, rdata);
        end
        tick();
        @(negedge clk); tests++;
        if ({cpu_rvalid, ldr_rvalid, rdata} !== {2'b01, 8'hA4}) begin
            fails++; $display("FAIL pipe_ldr_data: rv=%b%b rdata=%h, required 01 a4", cpu_rvalid, ldr_rvalid, rdata);
        end
        idle(2);
    endtask

    task automatic test_write_read();
        ldr_req = 1; ldr_lock = 0; ldr_wr = 1; ldr_addr = 5'd9; ldr_wdata = 8'h5C;
        tick(); ldr_req = 0; cpu_req = 1; cpu_wr = 0; cpu_addr = 5'd9;
        tick(); cpu_req = 0;
        tick();
        @(negedge clk); tests++;
        if ({cpu_rvalid, rdata} !== {1'b1, 8'h5C}) begin
            fails++; $display("FAIL wr_then_rd: rv=%b rdata=%h, required 1 5c", cpu_rvalid, rdata);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'd2;
        tick(); cpu_req = 0;
        rst = 1; #1; tests++;
        if (mem_rd !== 1'b0) begin fails++; $display("FAIL rst_async_rd: mem_rd=%b, required 0", mem_rd); end
        tick(); tick(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); tests++;
            if ({cpu_rvalid, ldr_rvalid, owner} !== 4'b0000) begin
                fails++; $display("FAIL rst_flush%0d: rv=%b%b owner=%b, required 00 00", i, cpu_rvalid, ldr_rvalid, owner);
            end
            tick();
        end
        ldr_req = 1; ldr_lock = 1; ldr_wr = 0; ldr_addr = 5'd5;
        tick(); ldr_req = 0; cpu_req = 1;
        @(negedge clk); tests++;
        if (cpu_gnt !== 1'b0) begin fails++; $display("FAIL rst_in_lock: cpu_gnt=%b, required 0", cpu_gnt); end
        tick(); rst = 1;
        @(negedge clk); tests++;
        if ({cpu_gnt, ldr_gnt} !== 2'b00) begin fails++; $display("FAIL rst_force_gnt: gnt=%b, required 00", {cpu_gnt, ldr_gnt}); end
        tick(); rst = 0; ldr_req = 1; ldr_lock = 0;
        @(negedge clk); tests++;
        if ({cpu_gnt, ldr_gnt} !== 2'b10) begin fails++; $display("FAIL rst_fsm_cpu_pri: cpu/ldr gnt=%b, required 10", {cpu_gnt, ldr_gnt}); end
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'(i * 5 + 1);
            shadow[i] = 8'(i * 5 + 1);
        end
        mem[5'h1A] = 8'hB7;
        shadow[5'h1A] = 8'hB7;
        mem_rdata = 8'h00;
        test_reset();
        test_cpu_read();
        test_starvation();
        test_lock();
        test_pipelined();
        test_write_read();
        test_reset_mid();
        tests++;
        if (sbq.size() != 0) begin fails++; $display("FAIL sb_drain: %0d reads never returned, required 0", sbq.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
